// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit sitting downstream of the ALU.
//
// Runs one data-memory transaction per accepted `start` over a req/ack
// handshake, steering store bytes onto the right lanes and sign/zero-extending
// load results for writeback. Every output is registered.
//
// Parameters:
//   ACK_TIMEOUT  max cycles spent in REQ waiting for mem_ack (0 = no timeout)
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses
//                         complete without a memory access and fault = 01.
//                         When undefined, halfwords use only addr[1] and
//                         words ignore addr[1:0].
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request a transaction (sampled only in IDLE)
//   opcode, funct3      LOAD/STORE opcode and access size/signedness
//   addr, wdata         effective byte address, store data (rs2)
//   busy, done          busy outside IDLE; one-cycle completion pulse
//   rdata               extended load result (0 after a store or a fault)
//   fault               00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//   mem_req, mem_we     memory request / write strobe
//   mem_be              byte enables
//   mem_addr            word-aligned address
//   mem_wdata           lane-steered store data
//   mem_ack, mem_rdata  memory acknowledge and load data word
// -----------------------------------------------------------------------------
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef STORE
`define STORE 7'b0100011
`endif

module lsu #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  localparam bit TIMEOUT_EN = (ACK_TIMEOUT != 0);
  localparam int CNT_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  // Last REQ cycle index: counting from 0, mem_req is high ACK_TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic              busy_d, done_d, mem_req_d, mem_we_d;
  logic [31:0]       rdata_d, mem_addr_d, mem_wdata_d;
  logic [1:0]        fault_d;
  logic [3:0]        mem_be_d;

  logic is_load, is_store, illegal, misaligned;

  // Lane select plus extension of the returned word.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'h0, b};
      3'b101:  load_extract = {16'h0, h};
      default: load_extract = word;
    endcase
  endfunction

  always_comb begin
    is_load  = (opcode == `LOAD);
    is_store = (opcode == `STORE);
    // Loads: 011/110/111 have no meaning. Stores: only SB/SH/SW exist.
    illegal  = is_load ? (funct3 inside {3'b011, 3'b110, 3'b111})
                       : (funct3 > 3'b010);
`ifdef LSU_MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    busy_d      = busy;
    done_d      = 1'b0;
    rdata_d     = rdata;
    fault_d     = fault;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_be_d    = mem_be;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;

    case (state_q)
      IDLE: begin
        if (start && (is_load || is_store)) begin
          funct3_d = funct3;
          lane_d   = addr[1:0];
          busy_d   = 1'b1;
          if (illegal || misaligned) begin
            state_d = DONE;
            done_d  = 1'b1;
            rdata_d = 32'h0;
            fault_d = illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
          end else begin
            state_d    = REQ;
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_we_d   = is_store;
            mem_addr_d = {addr[31:2], 2'b00};
            if (is_load) begin
              mem_be_d    = 4'b1111;
              mem_wdata_d = 32'h0;
            end else begin
              case (funct3[1:0])
                2'b00: begin
                  mem_be_d    = 4'b0001 << addr[1:0];
                  mem_wdata_d = {4{wdata[7:0]}};
                end
                2'b01: begin
                  mem_be_d    = addr[1] ? 4'b1100 : 4'b0011;
                  mem_wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                  mem_be_d    = 4'b1111;
                  mem_wdata_d = wdata;
                end
              endcase
            end
          end
        end
      end

      REQ: begin
        // An ack in the final allowed cycle wins over the timeout.
        if (mem_ack) begin
          state_d   = DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          fault_d   = FAULT_OK;
          rdata_d   = mem_we ? 32'h0 : load_extract(funct3_q, lane_q, mem_rdata);
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          fault_d   = FAULT_TIMEOUT;
          rdata_d   = 32'h0;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      funct3_q  <= 3'b000;
      lane_q    <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 32'h0;
      fault     <= FAULT_OK;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      lane_q    <= lane_d;
      busy      <= busy_d;
      done      <= done_d;
      rdata     <= rdata_d;
      fault     <= fault_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_be    <= mem_be_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- directed self-checking bench for lsu (ACK_TIMEOUT = 4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_lsu;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  fault;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  lsu #(.ACK_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns in cycle 1 after start.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    opcode = op;
    funct3 = f3;
    addr   = a;
    wdata  = wd;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Ack during the current cycle with the given load data.
  task automatic ack_now(input logic [31:0] rd);
    mem_rdata = rd;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
  endtask

  // Single-cycle-ack load; checks completion values.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    issue(OP_LOAD, f3, a, 32'h0);
    check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    ack_now(rd);
    check({tag, "_done"}, {31'h0, done}, 32'd1);
    check({tag, "_rdata"}, rdata, exp);
    tick();
  endtask

  // Single-cycle-ack store; checks steering.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    issue(OP_STORE, f3, a, wd);
    check({tag, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
    check({tag, "_wdata"}, mem_wdata, exp_wd);
    ack_now(32'hFFFF_FFFF);
    check({tag, "_rdata"}, rdata, 32'h0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_cycles;

    rst_n     = 1'b0;
    start     = 1'b0;
    opcode    = 7'h0;
    funct3    = 3'h0;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_busy",  {31'h0, busy},    32'd0);
    check("rst_done",  {31'h0, done},    32'd0);
    check("rst_req",   {31'h0, mem_req}, 32'd0);
    check("rst_we",    {31'h0, mem_we},  32'd0);
    check("rst_be",    {28'h0, mem_be},  32'd0);
    check("rst_fault", {30'h0, fault},   32'd0);
    check("rst_rdata", rdata,            32'h0);
    check("rst_maddr", mem_addr,         32'h0);
    check("rst_mwd",   mem_wdata,        32'h0);

    // LB, ack in first REQ cycle: done in cycle 2
    issue(OP_LOAD, 3'b000, 32'h0000_1003, 32'h0);
    check("lb_req",   {31'h0, mem_req}, 32'd1);
    check("lb_busy",  {31'h0, busy},    32'd1);
    check("lb_done0", {31'h0, done},    32'd0);
    check("lb_addr",  mem_addr,         32'h0000_1000);
    check("lb_be",    {28'h0, mem_be},  32'hF);
    check("lb_we",    {31'h0, mem_we},  32'd0);
    ack_now(32'h80FF_FF00);
    check("lb_done",  {31'h0, done},    32'd1);
    check("lb_rdata", rdata,            32'hFFFF_FF80);
    check("lb_fault", {30'h0, fault},   32'd0);
    check("lb_reqlo", {31'h0, mem_req}, 32'd0);
    tick();
    check("lb_pulse", {31'h0, done},    32'd0);
    check("lb_idle",  {31'h0, busy},    32'd0);
    check("lb_hold",  rdata,            32'hFFFF_FF80);

    // SH with ack after 3 REQ cycles: outputs stable throughout
    issue(OP_STORE, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("sh_req%0d", i), {31'h0, mem_req}, 32'd1);
      check($sformatf("sh_we%0d", i),  {31'h0, mem_we},  32'd1);
      check($sformatf("sh_be%0d", i),  {28'h0, mem_be},  32'hC);
      check($sformatf("sh_wd%0d", i),  mem_wdata,        32'hABCD_ABCD);
      if (i < 3) tick();
    end
    ack_now(32'h0);
    check("sh_done",  {31'h0, done},  32'd1);
    check("sh_rdata", rdata,          32'h0);
    check("sh_fault", {30'h0, fault}, 32'd0);
    tick();

    // Load extraction variants
    do_load("lhu", 3'b101, 32'h0000_0010, 32'hFFFF_8001, 32'h0000_8001);
    do_load("lh",  3'b001, 32'h0000_0012, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lbu", 3'b100, 32'h0000_1001, 32'h0000_9A00, 32'h0000_009A);
    do_load("lw",  3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Store steering variants
    do_store("sb", 3'b000, 32'h0000_3001, 32'h0000_0055, 4'b0010, 32'h5555_5555);
    do_store("sw", 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Leave a non-zero rdata behind so the timeout must clear it
    do_load("lw2", 3'b010, 32'h0000_0024, 32'h0F0F_0F0F, 32'h0F0F_0F0F);

    // Timeout: no ack, mem_req high for exactly 4 cycles
    issue(OP_LOAD, 3'b010, 32'h0000_0030, 32'h0);
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) break;
      if (mem_req) req_cycles++;
      tick();
    end
    check("to_reqcyc", req_cycles,      32'd4);
    check("to_done",   {31'h0, done},   32'd1);
    check("to_fault",  {30'h0, fault},  32'd2);
    check("to_rdata",  rdata,           32'h0);
    tick();

    // Ack coincident with the last allowed cycle counts as an ack
    issue(OP_LOAD, 3'b010, 32'h0000_0030, 32'h0);
    repeat (3) tick();
    check("ta_req4", {31'h0, mem_req}, 32'd1);
    ack_now(32'h1122_3344);
    check("ta_done",  {31'h0, done},  32'd1);
    check("ta_fault", {30'h0, fault}, 32'd0);
    check("ta_rdata", rdata,          32'h1122_3344);
    tick();

    // Illegal funct3 on a load: done in cycle 1, no access
    issue(OP_LOAD, 3'b011, 32'h0000_0040, 32'h0);
    check("il_done",  {31'h0, done},    32'd1);
    check("il_fault", {30'h0, fault},   32'd3);
    check("il_req",   {31'h0, mem_req}, 32'd0);
    check("il_rdata", rdata,            32'h0);
    tick();

    // Illegal funct3 on a store
    issue(OP_STORE, 3'b100, 32'h0000_0040, 32'h0);
    check("ils_fault", {30'h0, fault},   32'd3);
    check("ils_req",   {31'h0, mem_req}, 32'd0);
    tick();

    // Misaligned LW at 0x2
    issue(OP_LOAD, 3'b010, 32'h0000_0002, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("ma_done",  {31'h0, done},    32'd1);
    check("ma_fault", {30'h0, fault},   32'd1);
    check("ma_req",   {31'h0, mem_req}, 32'd0);
    check("ma_rdata", rdata,            32'h0);
`else
    check("ma_req",   {31'h0, mem_req}, 32'd1);
    check("ma_addr",  mem_addr,         32'h0);
    ack_now(32'h0BAD_F00D);
    check("ma_done",  {31'h0, done},    32'd1);
    check("ma_fault", {30'h0, fault},   32'd0);
    check("ma_rdata", rdata,            32'h0BAD_F00D);
`endif
    tick();

    // Non-LOAD/STORE opcode is ignored
    issue(OP_ALU, 3'b000, 32'h0000_0050, 32'h0);
    check("op_busy", {31'h0, busy},    32'd0);
    check("op_req",  {31'h0, mem_req}, 32'd0);

    // Start while busy is ignored
    issue(OP_STORE, 3'b010, 32'h0000_0050, 32'h0000_0001);
    opcode = OP_LOAD;
    funct3 = 3'b010;
    addr   = 32'h0000_0060;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("sb_addr", mem_addr,        32'h0000_0050);
    check("sb_we",   {31'h0, mem_we}, 32'd1);
    ack_now(32'h0);
    check("sb_done", {31'h0, done},   32'd1);
    tick();
    check("sb_idle", {31'h0, busy},   32'd0);
    check("sb_noreq", {31'h0, mem_req}, 32'd0);

    // Reset mid-REQ drops mem_req without a clock edge
    issue(OP_LOAD, 3'b010, 32'h0000_0070, 32'h0);
    tick();
    check("rr_req1", {31'h0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_req0",  {31'h0, mem_req}, 32'd0);
    check("rr_busy0", {31'h0, busy},    32'd0);
    tick();
    rst_n = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    mem_ack   = 1'b1;
    tick();
    check("rr_nodone1", {31'h0, done}, 32'd0);
    tick();
    mem_ack = 1'b0;
    check("rr_nodone2", {31'h0, done}, 32'd0);
    check("rr_rdata",   rdata,         32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
